// File: rtl/load_extend_if.sv
// Load-formatter request/result bundle: request side (IN_*), result side (OUT_*), FLUSH.
// Both sides use valid/ready; a transfer happens on a rising edge where valid && ready.
interface load_extend_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              FLUSH;
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] IN_DATA;
  logic [OFF_W-1:0]  IN_ADDR;
  logic [1:0]        IN_SIZE;
  logic              IN_SIGNED;
  logic [TAG_W-1:0]  IN_TAG;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic [TAG_W-1:0]  OUT_TAG;
  logic              OUT_ERR;

  modport slave (
    input  FLUSH, IN_VALID, IN_DATA, IN_ADDR, IN_SIZE, IN_SIGNED, IN_TAG, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_TAG, OUT_ERR
  );

  modport master (
    output FLUSH, IN_VALID, IN_DATA, IN_ADDR, IN_SIZE, IN_SIGNED, IN_TAG, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_TAG, OUT_ERR
  );
endinterface

// File: rtl/load_extend_unit.sv
// Load-data formatter: lane select, sign/zero extension and alignment check,
// buffered through a 2-entry FIFO so a write-back stall never drops a result.
module load_extend_unit #(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 5,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic           CLK,
  input  logic           RST_N,
  load_extend_if.slave   bus,
  output logic [1:0]     dbg_state_o
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  entry_t           fmt;
  logic             push, pop;
  logic [OFF_W+1:0] sz_bytes, addr_ext, off;
  logic [DATA_W-1:0] shifted, mask;
  logic             sgn, err;

  // Big-endian places a field of sz bytes at byte offset NB-sz-addr; for aligned
  // accesses this equals mirroring the field index at its own granularity.
  always_comb begin
    sz_bytes = (OFF_W+2)'(1) << bus.IN_SIZE;
    addr_ext = (OFF_W+2)'(bus.IN_ADDR);
    off      = BIG_ENDIAN ? ((OFF_W+2)'(NB) - sz_bytes - addr_ext) : addr_ext;
    shifted  = bus.IN_DATA >> {off, 3'b000};
    mask     = '0;
    sgn      = 1'b0;
    err      = 1'b0;
    case (bus.IN_SIZE)
      2'd0: begin mask[7:0]  = '1; sgn = shifted[7]; end
      2'd1: begin mask[15:0] = '1; sgn = shifted[15]; err = bus.IN_ADDR[0]; end
      2'd2: begin mask[31:0] = '1; sgn = shifted[31]; err = (bus.IN_ADDR[1:0] != 2'b00); end
      default: begin mask = '1; err = (DATA_W == 32) || (bus.IN_ADDR != '0); end
    endcase
    fmt.tag  = bus.IN_TAG;
    fmt.err  = err;
    fmt.data = err ? '0 : ((shifted & mask) | ((bus.IN_SIGNED && sgn) ? ~mask : '0));
  end

  assign push = bus.IN_VALID && bus.IN_READY;
  assign pop  = (state_q != EMPTY) && bus.OUT_READY && !bus.FLUSH;

  always_comb begin
    state_d = state_q;
    if (bus.FLUSH) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = FULL;
          else if (pop && !push) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (bus.FLUSH) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= fmt;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // IN_READY depends only on registered state, never on OUT_READY.
  assign bus.IN_READY  = RST_N && !bus.FLUSH && (state_q != FULL);
  assign bus.OUT_VALID = (state_q != EMPTY);
  assign bus.OUT_DATA  = mem_q[rd_ptr_q].data;
  assign bus.OUT_TAG   = mem_q[rd_ptr_q].tag;
  assign bus.OUT_ERR   = mem_q[rd_ptr_q].err;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_load_extend_unit.sv
// Bench for load_extend_unit: three instances (32-bit LE, 32-bit BE, 64-bit LE)
// checked every cycle against a queue-based model fed by directed vectors.
module tb_load_extend_unit;
  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        err;
  } res_t;

  typedef struct {
    int          d;
    logic [63:0] data;
    int          addr;
    int          size;
    bit          sgn;
    logic [63:0] exp;
    bit          err;
  } vec_t;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  logic [2:0]        in_valid  = '0;
  logic [2:0]        flush     = '0;
  logic [2:0]        out_ready = '0;
  logic [2:0]        in_signed = '0;
  logic [2:0][63:0]  in_data   = '0;
  logic [2:0][2:0]   in_addr   = '0;
  logic [2:0][1:0]   in_size   = '0;
  logic [2:0][4:0]   in_tag    = '0;
  logic [2:0]        in_ready, out_valid, out_err;
  logic [2:0][63:0]  out_data;
  logic [2:0][4:0]   out_tag;
  logic [1:0]        dbg0, dbg1, dbg2;

  load_extend_if #(.DATA_W(32), .TAG_W(5)) bus0 ();
  load_extend_if #(.DATA_W(32), .TAG_W(5)) bus1 ();
  load_extend_if #(.DATA_W(64), .TAG_W(5)) bus2 ();

  assign bus0.FLUSH = flush[0];  assign bus0.IN_VALID = in_valid[0];
  assign bus0.IN_DATA = in_data[0][31:0];  assign bus0.IN_ADDR = in_addr[0][1:0];
  assign bus0.IN_SIZE = in_size[0];  assign bus0.IN_SIGNED = in_signed[0];
  assign bus0.IN_TAG = in_tag[0];  assign bus0.OUT_READY = out_ready[0];

  assign bus1.FLUSH = flush[1];  assign bus1.IN_VALID = in_valid[1];
  assign bus1.IN_DATA = in_data[1][31:0];  assign bus1.IN_ADDR = in_addr[1][1:0];
  assign bus1.IN_SIZE = in_size[1];  assign bus1.IN_SIGNED = in_signed[1];
  assign bus1.IN_TAG = in_tag[1];  assign bus1.OUT_READY = out_ready[1];

  assign bus2.FLUSH = flush[2];  assign bus2.IN_VALID = in_valid[2];
  assign bus2.IN_DATA = in_data[2];  assign bus2.IN_ADDR = in_addr[2];
  assign bus2.IN_SIZE = in_size[2];  assign bus2.IN_SIGNED = in_signed[2];
  assign bus2.IN_TAG = in_tag[2];  assign bus2.OUT_READY = out_ready[2];

  assign in_ready  = {bus2.IN_READY, bus1.IN_READY, bus0.IN_READY};
  assign out_valid = {bus2.OUT_VALID, bus1.OUT_VALID, bus0.OUT_VALID};
  assign out_err   = {bus2.OUT_ERR, bus1.OUT_ERR, bus0.OUT_ERR};
  assign out_data  = {64'(bus2.OUT_DATA), 64'(bus1.OUT_DATA), 64'(bus0.OUT_DATA)};
  assign out_tag   = {bus2.OUT_TAG, bus1.OUT_TAG, bus0.OUT_TAG};

  load_extend_unit #(.DATA_W(32), .TAG_W(5), .BIG_ENDIAN(1'b0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .bus(bus0.slave), .dbg_state_o(dbg0));
  load_extend_unit #(.DATA_W(32), .TAG_W(5), .BIG_ENDIAN(1'b1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .bus(bus1.slave), .dbg_state_o(dbg1));
  load_extend_unit #(.DATA_W(64), .TAG_W(5), .BIG_ENDIAN(1'b0)) dut2 (
    .CLK(clk), .RST_N(rst_n), .bus(bus2.slave), .dbg_state_o(dbg2));

  // model: field of 2**size bytes at byte position addr (LE) or nb-bytes-addr (BE)
  function automatic res_t model(int dw, bit be, logic [63:0] raw, int addr, int size,
                                 bit sgn, logic [4:0] tag);
    res_t r;
    int nb, bytes, pos;
    logic [63:0] field, fmask;
    nb = dw / 8;
    bytes = 1 << size;
    r.data = '0;
    r.tag  = tag;
    r.err  = 1'b0;
    if (bytes > nb || (addr % bytes) != 0) begin
      r.err = 1'b1;
      return r;
    end
    pos   = be ? (nb - bytes - addr) : addr;
    fmask = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
    field = (raw >> (8 * pos)) & fmask;
    if (bytes < nb && sgn && field[8 * bytes - 1]) field = field | ~fmask;
    if (dw == 32) field = field & 64'hFFFF_FFFF;
    r.data = field;
    return r;
  endfunction

  // scoreboard
  res_t exp0[$];
  res_t exp1[$];
  res_t exp2[$];
  logic [4:0] popped_tags[$];
  logic [2:0] will_push  = '0;
  logic [2:0] will_pop   = '0;
  logic [2:0] will_flush = '0;
  res_t pend [3];

  function automatic int qsize(int d);
    case (d)
      0: return exp0.size();
      1: return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  function automatic res_t qfront(int d);
    case (d)
      0: return exp0[0];
      1: return exp1[0];
      default: return exp2[0];
    endcase
  endfunction

  task automatic q_push(int d, res_t r);
    case (d)
      0: exp0.push_back(r);
      1: exp1.push_back(r);
      default: exp2.push_back(r);
    endcase
  endtask

  task automatic q_pop(int d);
    case (d)
      0: void'(exp0.pop_front());
      1: void'(exp1.pop_front());
      default: void'(exp2.pop_front());
    endcase
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // compare process: DUT outputs vs model on every falling edge
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int   qs;
      int   dw;
      logic exp_rdy;
      res_t h;
      dw = (d == 2) ? 64 : 32;
      qs = qsize(d);
      exp_rdy = rst_n && !flush[d] && (qs < 2);
      chk($sformatf("in_ready[%0d]", d), 64'(in_ready[d]), 64'(exp_rdy));
      chk($sformatf("out_valid[%0d]", d), 64'(out_valid[d]), 64'(qs != 0));
      if (qs != 0) begin
        h = qfront(d);
        chk($sformatf("out_data[%0d]", d), out_data[d], h.data);
        chk($sformatf("out_tag[%0d]", d), 64'(out_tag[d]), 64'(h.tag));
        chk($sformatf("out_err[%0d]", d), 64'(out_err[d]), 64'(h.err));
      end
      if (d == 0 && rst_n && out_valid[0] && out_ready[0] && !flush[0])
        popped_tags.push_back(out_tag[0]);
      will_push[d]  = in_valid[d] && exp_rdy;
      will_pop[d]   = rst_n && (qs != 0) && out_ready[d] && !flush[d];
      will_flush[d] = rst_n && flush[d];
      pend[d] = model(dw, d == 1, in_data[d], (dw == 32) ? int'(in_addr[d][1:0]) : int'(in_addr[d]),
                      int'(in_size[d]), in_signed[d], in_tag[d]);
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (will_flush[d]) begin
          case (d)
            0: exp0.delete();
            1: exp1.delete();
            default: exp2.delete();
          endcase
        end else begin
          if (will_pop[d])  q_pop(d);
          if (will_push[d]) q_push(d, pend[d]);
        end
      end
    end
  end

  always @(negedge rst_n) begin
    exp0.delete();
    exp1.delete();
    exp2.delete();
    will_push  = '0;
    will_pop   = '0;
    will_flush = '0;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(int d, logic [63:0] data, int addr, int size, bit sgn, logic [4:0] tag);
    logic ok;
    in_data[d]   = data;
    in_addr[d]   = 3'(addr);
    in_size[d]   = 2'(size);
    in_signed[d] = sgn;
    in_tag[d]    = tag;
    in_valid[d]  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready[d];
      tick();
    end
    in_valid[d] = 1'b0;
    chk("push_accepted", 64'(ok), 64'd1);
  endtask

  task automatic vec(int d, logic [63:0] data, int addr, int size, bit sgn, logic [4:0] tag,
                     logic [63:0] exp_d, bit exp_e);
    res_t m;
    m = model((d == 2) ? 64 : 32, d == 1, data, addr, size, sgn, tag);
    chk("model_pin_data", m.data, exp_d);
    chk("model_pin_err", 64'(m.err), 64'(exp_e));
    push_req(d, data, addr, size, sgn, tag);
    chk("lat_valid", 64'(out_valid[d]), 64'd1);
    chk("lat_data", out_data[d], exp_d);
    chk("lat_err", 64'(out_err[d]), 64'(exp_e));
    chk("lat_tag", 64'(out_tag[d]), 64'(tag));
  endtask

  vec_t vt[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_out_data", out_data[0], 64'd0);
    chk("rst_out_tag", 64'(out_tag[0]), 64'd0);
    chk("rst_out_err", 64'(out_err[0]), 64'd0);
    chk("rst_in_ready", 64'(in_ready[0]), 64'd0);
    chk("rst_state", 64'(dbg0), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready[0]), 64'd1);

    // directed formatting vectors: d, data, addr, size, signed, expected, err
    out_ready = '1;
    vt.push_back('{0, 64'h12AB34F0, 0, 0, 1'b1, 64'hFFFFFFF0, 1'b0});
    vt.push_back('{0, 64'h12AB34F0, 2, 0, 1'b0, 64'h000000AB, 1'b0});
    vt.push_back('{0, 64'h12AB34F0, 3, 0, 1'b1, 64'h00000012, 1'b0});
    vt.push_back('{0, 64'h12AB34F0, 1, 0, 1'b1, 64'h00000034, 1'b0});
    vt.push_back('{0, 64'h80017FFF, 2, 1, 1'b1, 64'hFFFF8001, 1'b0});
    vt.push_back('{0, 64'h80017FFF, 0, 1, 1'b0, 64'h00007FFF, 1'b0});
    vt.push_back('{0, 64'h80017FFF, 0, 1, 1'b1, 64'h00007FFF, 1'b0});
    vt.push_back('{0, 64'h80017FFF, 1, 1, 1'b1, 64'h0, 1'b1});
    vt.push_back('{0, 64'hDEADBEEF, 0, 2, 1'b1, 64'hDEADBEEF, 1'b0});
    vt.push_back('{0, 64'hDEADBEEF, 2, 2, 1'b0, 64'h0, 1'b1});
    vt.push_back('{0, 64'hDEADBEEF, 0, 3, 1'b0, 64'h0, 1'b1});
    vt.push_back('{1, 64'h80017FFF, 0, 1, 1'b1, 64'hFFFF8001, 1'b0});
    vt.push_back('{1, 64'h80017FFF, 2, 1, 1'b0, 64'h00007FFF, 1'b0});
    vt.push_back('{1, 64'h12AB34F0, 0, 0, 1'b1, 64'h00000012, 1'b0});
    vt.push_back('{1, 64'h12AB34F0, 3, 0, 1'b1, 64'hFFFFFFF0, 1'b0});
    vt.push_back('{1, 64'h12AB34F0, 1, 0, 1'b0, 64'h000000AB, 1'b0});
    vt.push_back('{2, 64'h80000000_00000001, 4, 2, 1'b1, 64'hFFFFFFFF_80000000, 1'b0});
    vt.push_back('{2, 64'h80000000_00000001, 0, 3, 1'b1, 64'h80000000_00000001, 1'b0});
    vt.push_back('{2, 64'h80000000_00000001, 4, 3, 1'b0, 64'h0, 1'b1});
    vt.push_back('{2, 64'h80000000_00000001, 4, 2, 1'b0, 64'h00000000_80000000, 1'b0});
    vt.push_back('{2, 64'h80000000_00000001, 7, 0, 1'b1, 64'hFFFFFFFF_FFFFFF80, 1'b0});
    vt.push_back('{2, 64'h80000000_00000001, 6, 1, 1'b0, 64'h00000000_00008000, 1'b0});
    vt.push_back('{2, 64'h80000000_00000001, 0, 2, 1'b1, 64'h00000000_00000001, 1'b0});
    vt.push_back('{2, 64'h80000000_00000001, 2, 2, 1'b0, 64'h0, 1'b1});
    foreach (vt[i])
      vec(vt[i].d, vt[i].data, vt[i].addr, vt[i].size, vt[i].sgn, 5'(i + 1), vt[i].exp, vt[i].err);
    repeat (2) tick();

    // backpressure: three requests against a stalled consumer
    out_ready = '0;
    popped_tags.delete();
    push_req(0, 64'h11, 0, 0, 1'b0, 5'd1);
    push_req(0, 64'h22, 0, 0, 1'b0, 5'd2);
    chk("bp_in_ready_full", 64'(in_ready[0]), 64'd0);
    chk("bp_state_full", 64'(dbg0), 64'd2);
    fork
      push_req(0, 64'h33, 0, 0, 1'b0, 5'd3);
      begin
        tick();
        tick();
        chk("bp_stall_ready", 64'(in_ready[0]), 64'd0);
        chk("bp_stall_tag", 64'(out_tag[0]), 64'd1);
        out_ready[0] = 1'b1;
      end
    join
    repeat (4) tick();
    chk("bp_pop_count", 64'(popped_tags.size()), 64'd3);
    if (popped_tags.size() == 3) begin
      chk("bp_pop0", 64'(popped_tags[0]), 64'd1);
      chk("bp_pop1", 64'(popped_tags[1]), 64'd2);
      chk("bp_pop2", 64'(popped_tags[2]), 64'd3);
    end

    // simultaneous push and pop while holding one entry
    out_ready[0] = 1'b0;
    push_req(0, 64'h44, 0, 0, 1'b0, 5'd4);
    chk("sim_state_one", 64'(dbg0), 64'd1);
    out_ready[0] = 1'b1;
    push_req(0, 64'h55, 0, 0, 1'b0, 5'd5);
    out_ready[0] = 1'b0;
    chk("sim_state_kept", 64'(dbg0), 64'd1);
    chk("sim_head_tag", 64'(out_tag[0]), 64'd5);
    chk("sim_head_data", out_data[0], 64'h55);

    // flush with two entries held
    push_req(0, 64'h66, 0, 0, 1'b0, 5'd6);
    chk("fl_state_full", 64'(dbg0), 64'd2);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    chk("fl_out_valid", 64'(out_valid[0]), 64'd0);
    chk("fl_state", 64'(dbg0), 64'd0);
    tick();

    // asynchronous reset pulse between edges
    push_req(0, 64'h99, 0, 0, 1'b0, 5'd7);
    chk("ar_before_valid", 64'(out_valid[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid[0]), 64'd0);
    chk("ar_out_data", out_data[0], 64'd0);
    chk("ar_out_tag", 64'(out_tag[0]), 64'd0);
    chk("ar_in_ready", 64'(in_ready[0]), 64'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ar_release_ready", 64'(in_ready[0]), 64'd1);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
